add_iter_bw16: RTL and testbench

ADD_ITER_BW16 -- requirements
Module: add_iter_bw16

---
 rtl/add_iter_bw16_pkg.sv | 5 +
 rtl/add_iter_bw16_if.sv | 15 +
 rtl/add_iter_bw16.sv | 77 +++++++
 tb/tb_add_iter_bw16.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/add_iter_bw16_pkg.sv
// add_iter_bw16_pkg: shared state encoding and defaults for iteration controllers
package add_iter_bw16_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT_LO, WAIT_HI, DONE} state_t;
  localparam int TMO_DEF = 255;
endpackage

// File: rtl/add_iter_bw16_if.sv
// add_iter_bw16_if: job request/result and successor-stage handshake bundle
interface add_iter_bw16_if #(parameter int BW = 16);
  logic st;
  logic [BW-1:0] x;
  logic [BW-1:0] y;
  logic rd;
  logic [BW-1:0] res;
  logic err;
  logic s_st;
  logic [BW-1:0] s_in;
  logic s_rd;
  logic [BW-1:0] s_res;
  modport master(output st, x, y, s_rd, s_res, input rd, res, err, s_st, s_in);
  modport slave(input st, x, y, s_rd, s_res, output rd, res, err, s_st, s_in);
endinterface

// File: rtl/add_iter_bw16.sv
// add_iter_bw16: computes x+y by stepping an external successor stage y times from x
module add_iter_bw16
  import add_iter_bw16_pkg::*;
#(
  parameter int BW  = 16,
  parameter int TMO = TMO_DEF
) (
  input logic clk,
  input logic rst_n,
  add_iter_bw16_if.slave bus
);
  localparam int WW = $clog2(TMO + 1);
  state_t state;
  logic [BW-1:0] acc;
  logic [BW-1:0] cnt;
  logic [WW-1:0] wd;
  logic st_q;
  logic wd_exp;
  assign wd_exp = (wd == WW'(TMO - 1));
  // controller: one successor handshake per iteration, watchdog guards each wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      wd       <= '0;
      st_q     <= 1'b0;
      bus.rd   <= 1'b1;
      bus.res  <= '0;
      bus.err  <= 1'b0;
      bus.s_st <= 1'b0;
      bus.s_in <= '0;
    end else begin
      st_q <= bus.st;
      case (state)
        IDLE: if (bus.st && !st_q) begin
          acc     <= bus.x;
          cnt     <= bus.y;
          bus.err <= 1'b0;
          bus.rd  <= 1'b0;
          state   <= LOAD;
        end
        LOAD: if (cnt == '0) state <= DONE;
        else begin
          bus.s_in <= acc;
          bus.s_st <= 1'b1;
          state    <= PULSE;
        end
        PULSE: begin
          bus.s_st <= 1'b0;
          wd       <= '0;
          state    <= WAIT_LO;
        end
        WAIT_LO, WAIT_HI: if (wd_exp) begin
          bus.err <= 1'b1;
          bus.rd  <= 1'b1;
          bus.res <= acc;
          state   <= IDLE;
        end else begin
          wd <= wd + 1'b1;
          if (state == WAIT_LO && !bus.s_rd) state <= WAIT_HI;
          else if (state == WAIT_HI && bus.s_rd) begin
            acc   <= bus.s_res;
            cnt   <= cnt - 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          bus.res <= acc;
          bus.rd  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_iter_bw16.sv
// tb_add_iter_bw16: directed jobs against an arithmetic model with a behavioural successor stage
module tb_add_iter_bw16;
  localparam int BW = 16;
  localparam int TMO = 255;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  add_iter_bw16_if #(.BW(BW)) bus ();
  add_iter_bw16 #(.BW(BW), .TMO(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_res = '0;
  logic exp_err = 1'b0;
  logic exp_valid = 1'b0;
  bit stage_en = 1'b1;
  int lat = 3;
  int pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // successor stage: on each start strobe go busy for lat cycles, then return s_in+1
  initial begin
    logic [BW-1:0] v;
    bus.s_rd = 1'b1;
    bus.s_res = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stage_en && bus.s_st) begin
        pulses++;
        v = bus.s_in;
        bus.s_rd = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        bus.s_res = v + 1'b1;
        bus.s_rd = 1'b1;
      end
    end
  end

  // whenever a result is presented, it must match the model
  initial forever begin
    @(negedge clk);
    if (exp_valid && rst_n && bus.rd) begin
      chk("model_res", bus.res, exp_res);
      chk("model_err", bus.err, exp_err);
    end
  end

  task automatic wait_rd(input int budget, output int n);
    n = 0;
    while (!bus.rd && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.rd) chk("rd_timeout", bus.rd, 1);
  endtask

  task automatic job(input logic [BW-1:0] x, input logic [BW-1:0] y, input logic [BW-1:0] r,
                     input logic e, input int np, input int elat);
    int p0;
    int n;
    p0 = pulses;
    @(negedge clk);
    bus.x = x;
    bus.y = y;
    bus.st = 1'b1;
    @(posedge clk);
    exp_res = stage_en ? x + y : x;
    exp_err = !stage_en;
    exp_valid = 1'b1;
    #1;
    bus.st = 1'b0;
    chk("busy", bus.rd, 0);
    wait_rd(2000, n);
    if (elat >= 0) chk("latency", n, elat);
    @(negedge clk);
    chk("res", bus.res, r);
    chk("err", bus.err, e);
    chk("pulses", pulses - p0, np);
  endtask

  initial begin
    int p0;
    int n;
    bus.st = 1'b0;
    bus.x = '0;
    bus.y = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_rd", bus.rd, 1);
    chk("rst_res", bus.res, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_s_st", bus.s_st, 0);
    chk("rst_s_in", bus.s_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    job(16'd5, 16'd3, 16'd8, 1'b0, 3, -1);
    job(16'd1234, 16'd0, 16'd1234, 1'b0, 0, 2);
    job(16'hFFFE, 16'd3, 16'd1, 1'b0, 3, -1);
    job(16'hFFFF, 16'd1, 16'd0, 1'b0, 1, -1);
    lat = 2;
    job(16'd100, 16'd2, 16'd102, 1'b0, 2, -1);
    lat = 3;
    stage_en = 1'b0;
    job(16'd7, 16'd2, 16'd7, 1'b1, 0, TMO + 2);
    stage_en = 1'b1;
    job(16'd9, 16'd1, 16'd10, 1'b0, 1, -1);
    // reset in the middle of the second iteration
    p0 = pulses;
    @(negedge clk);
    bus.x = 16'd10;
    bus.y = 16'd4;
    bus.st = 1'b1;
    @(posedge clk);
    exp_valid = 1'b0;
    #1 bus.st = 1'b0;
    n = 0;
    while (pulses - p0 < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("second_iter_reached", pulses - p0, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd", bus.rd, 1);
    chk("midrst_res", bus.res, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_s_st", bus.s_st, 0);
    chk("midrst_s_in", bus.s_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_res = '0;
    exp_err = 1'b0;
    exp_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_rst", bus.rd, 1);
    job(16'd2, 16'd2, 16'd4, 1'b0, 2, -1);
    // start held high, plus a second edge while busy: only one job
    p0 = pulses;
    @(negedge clk);
    bus.x = 16'd0;
    bus.y = 16'd1;
    bus.st = 1'b1;
    @(posedge clk);
    exp_res = 16'd1;
    exp_err = 1'b0;
    #1;
    chk("hold_busy", bus.rd, 0);
    @(negedge clk);
    bus.st = 1'b0;
    @(negedge clk);
    bus.st = 1'b1;
    wait_rd(2000, n);
    repeat (10) @(negedge clk);
    chk("hold_rd", bus.rd, 1);
    chk("hold_res", bus.res, 16'd1);
    chk("hold_pulses", pulses - p0, 1);
    bus.st = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
